// File: rtl/kp_key_mapper_if.sv
// Keypad mapper bundle: scanner key level/index in, code strobe and page out.
interface kp_key_mapper_if #(
  parameter int PAGE_BITS = 1
);
  logic                   valid;
  logic [3:0]             d;
  logic [PAGE_BITS+3:0]   code;
  logic                   code_valid;
  logic [PAGE_BITS-1:0]   page;

  modport master (output valid, d, input code, code_valid, page);
  modport slave  (input valid, d, output code, code_valid, page);
endinterface

// File: rtl/kp_key_mapper.sv
// Keypad key-index to {page, digit} translator with paged shift key and
// optional auto-repeat of held mapped keys.
module kp_key_mapper #(
  parameter int         PAGE_BITS    = 1,
  parameter logic [3:0] SHIFT_KEY    = 4'h7,
  parameter bit         STICKY       = 1'b0,
  parameter bit         REPEAT_EN    = 1'b0,
  parameter int         CNT_W        = 20,
  parameter int         REPEAT_DELAY = 500000,
  parameter int         REPEAT_RATE  = 100000
) (
  input  logic          clk,
  input  logic          rst,
  kp_key_mapper_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  state_t                 state;
  logic                   prev_valid;
  logic [3:0]             prev_d;
  logic [CNT_W-1:0]       cnt;
  logic [PAGE_BITS-1:0]   page_q;
  logic [PAGE_BITS+3:0]   code_q;
  logic                   code_valid_q;

  logic                   press;
  logic                   mapped;
  logic                   is_shift;
  logic                   can_repeat;
  logic [3:0]             digit;

  // Returns {mapped, digit}; digit 4'hF on key 0 is the clear code.
  function automatic logic [4:0] map_key(input logic [3:0] k);
    case (k)
      4'd0:    map_key = 5'h1F;
      4'd1:    map_key = 5'h10;
      4'd4:    map_key = 5'h17;
      4'd5:    map_key = 5'h18;
      4'd6:    map_key = 5'h19;
      4'd8:    map_key = 5'h14;
      4'd9:    map_key = 5'h15;
      4'd10:   map_key = 5'h16;
      4'd12:   map_key = 5'h11;
      4'd13:   map_key = 5'h12;
      4'd14:   map_key = 5'h13;
      default: map_key = 5'h00;
    endcase
  endfunction

  always_comb begin
    press           = bus.valid && (!prev_valid || (bus.d != prev_d));
    {mapped, digit} = map_key(bus.d);
    is_shift        = (bus.d == SHIFT_KEY);
    can_repeat      = REPEAT_EN && mapped;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prev_valid   <= 1'b0;
      prev_d       <= 4'd0;
      cnt          <= '0;
      page_q       <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
    end else begin
      prev_valid   <= bus.valid;
      prev_d       <= bus.d;
      code_valid_q <= 1'b0;
      if (!bus.valid) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (press) begin
        state <= HELD;
        cnt   <= '0;
        if (mapped) begin
          code_q       <= {page_q, digit};
          code_valid_q <= 1'b1;
          if (!STICKY) page_q <= '0;
        end else if (is_shift) begin
          page_q <= page_q + 1'b1;
        end
      end else begin
        // Counter only runs for keys that can repeat, so it never wraps.
        case (state)
          HELD: begin
            if (can_repeat) begin
              if (cnt == DELAY_LAST) begin
                state        <= REPEAT;
                cnt          <= '0;
                code_q       <= {page_q, digit};
                code_valid_q <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (cnt == RATE_LAST) begin
              cnt          <= '0;
              code_q       <= {page_q, digit};
              code_valid_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.code       = code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.page       = page_q;

endmodule
